// File: rtl/rng_stat_monitor_if.sv
// Sample stream and result bus between the RNG test harness and rng_stat_monitor.
// in_valid qualifies in_data for one cycle; there is no ready, every valid beat in COLLECT is consumed.
interface rng_stat_monitor_if #(
   parameter int LOG2_N = 10
);
   logic                start;
   logic                in_valid;
   logic [31:0]         in_data;
   logic                busy;
   logic                done;
   logic [LOG2_N+5:0]   ones_count;
   logic [LOG2_N+5:0]   trans_count;
   logic                pass_mono;
   logic                pass_runs;

   modport master (
      output start, in_valid, in_data,
      input  busy, done, ones_count, trans_count, pass_mono, pass_runs
   );

   modport slave (
      input  start, in_valid, in_data,
      output busy, done, ones_count, trans_count, pass_mono, pass_runs
   );
endinterface

// File: rtl/rng_stat_monitor.sv
// Monobit and bit-transition quality check over a window of 2^LOG2_N 32-bit samples.
// Stage 1 registers per-word counts; stage 2 folds them into the window accumulators.
module rng_stat_monitor #(
   parameter int LOG2_N   = 10,
   parameter int MONO_TOL = 362,
   parameter int RUN_TOL  = 362
) (
   input  logic                clk,
   input  logic                rst,
   rng_stat_monitor_if.slave   bus,
   output logic [1:0]          dbg_state
);
   localparam int          W       = LOG2_N + 6;
   localparam int          N       = 1 << LOG2_N;
   localparam int unsigned CENTRE  = 32'(N * 16);
   localparam int unsigned MONO_LO = (MONO_TOL >= N * 16) ? 32'd0 : 32'(N * 16 - MONO_TOL);
   localparam int unsigned MONO_HI = CENTRE + 32'(MONO_TOL);
   localparam int unsigned RUN_LO  = (RUN_TOL >= N * 16) ? 32'd0 : 32'(N * 16 - RUN_TOL);
   localparam int unsigned RUN_HI  = CENTRE + 32'(RUN_TOL);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [LOG2_N-1:0] cnt_q, cnt_d;
   logic              first_q, first_d;
   logic              prev_lsb_q, prev_lsb_d;
   logic              s1_vld_q, s1_vld_d;
   logic [5:0]        s1_pop_q, s1_pop_d;
   logic [5:0]        s1_trans_q, s1_trans_d;
   logic [W-1:0]      acc_ones_q, acc_ones_d;
   logic [W-1:0]      acc_trans_q, acc_trans_d;
   logic [W-1:0]      ones_q, ones_d;
   logic [W-1:0]      trans_q, trans_d;
   logic              pmono_q, pmono_d;
   logic              pruns_q, pruns_d;
   logic              done_q, done_d;

   logic [5:0] pop;
   logic [5:0] itrans;
   logic       bnd;
   logic       accept;

   always_comb begin
      pop    = 6'd0;
      itrans = 6'd0;
      for (int i = 0; i < 32; i++) pop = pop + 6'(bus.in_data[i]);
      for (int i = 0; i < 31; i++) itrans = itrans + 6'(bus.in_data[i] ^ bus.in_data[i+1]);
      // The word boundary only counts once a previous word exists in this window.
      bnd = !first_q && (prev_lsb_q != bus.in_data[31]);
   end

   assign accept = (state_q == S_COLLECT) && bus.in_valid;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      first_d     = first_q;
      prev_lsb_d  = prev_lsb_q;
      s1_vld_d    = accept;
      s1_pop_d    = s1_pop_q;
      s1_trans_d  = s1_trans_q;
      acc_ones_d  = acc_ones_q;
      acc_trans_d = acc_trans_q;
      ones_d      = ones_q;
      trans_d     = trans_q;
      pmono_d     = pmono_q;
      pruns_d     = pruns_q;
      done_d      = 1'b0;

      if (s1_vld_q) begin
         acc_ones_d  = acc_ones_q + W'(s1_pop_q);
         acc_trans_d = acc_trans_q + W'(s1_trans_q);
      end

      if (accept) begin
         s1_pop_d   = pop;
         s1_trans_d = itrans + 6'(bnd);
         prev_lsb_d = bus.in_data[0];
         first_d    = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            // done_q marks the pulse cycle; a start coinciding with it is dropped.
            if (bus.start && !done_q) begin
               acc_ones_d  = '0;
               acc_trans_d = '0;
               cnt_d       = '0;
               first_d     = 1'b1;
               state_d     = S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (accept) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LOG2_N'(N - 1)) state_d = S_DRAIN;
            end
         end
         S_DRAIN: state_d = S_DONE;
         S_DONE: begin
            ones_d  = acc_ones_q;
            trans_d = acc_trans_q;
            pmono_d = (32'(acc_ones_q) >= MONO_LO) && (32'(acc_ones_q) <= MONO_HI);
            pruns_d = (32'(acc_trans_q) >= RUN_LO) && (32'(acc_trans_q) <= RUN_HI);
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         first_q     <= 1'b0;
         prev_lsb_q  <= 1'b0;
         s1_vld_q    <= 1'b0;
         s1_pop_q    <= '0;
         s1_trans_q  <= '0;
         acc_ones_q  <= '0;
         acc_trans_q <= '0;
         ones_q      <= '0;
         trans_q     <= '0;
         pmono_q     <= 1'b0;
         pruns_q     <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         first_q     <= first_d;
         prev_lsb_q  <= prev_lsb_d;
         s1_vld_q    <= s1_vld_d;
         s1_pop_q    <= s1_pop_d;
         s1_trans_q  <= s1_trans_d;
         acc_ones_q  <= acc_ones_d;
         acc_trans_q <= acc_trans_d;
         ones_q      <= ones_d;
         trans_q     <= trans_d;
         pmono_q     <= pmono_d;
         pruns_q     <= pruns_d;
         done_q      <= done_d;
      end
   end

   assign bus.busy        = (state_q == S_COLLECT) || (state_q == S_DRAIN);
   assign bus.done        = done_q;
   assign bus.ones_count  = ones_q;
   assign bus.trans_count = trans_q;
   assign bus.pass_mono   = pmono_q;
   assign bus.pass_runs   = pruns_q;
   assign dbg_state       = state_q;
endmodule

// File: tb/tb_rng_stat_monitor.sv
// Randomised bench for rng_stat_monitor with N=4, tolerances 8 (centre 64).
// The reference model treats each window as one 128-bit serial stream, MSB of the first word first.
module tb_rng_stat_monitor;
   localparam int LOG2_N = 2;
   localparam int TOL    = 8;
   localparam int NS     = 1 << LOG2_N;
   localparam int CENTRE = NS * 16;

   logic       clk;
   logic       rst;
   logic [1:0] dbg_state;

   rng_stat_monitor_if #(.LOG2_N(LOG2_N)) bus ();

   rng_stat_monitor #(.LOG2_N(LOG2_N), .MONO_TOL(TOL), .RUN_TOL(TOL)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks;
   int errors;

   logic [31:0] win [NS];
   int exp_ones, exp_trans;
   bit exp_pm, exp_pr;

   // results recorded by run_window
   int lat;
   int pulses;
   int busy_bad;
   int done_bad;
   bit busy_after_done;

   function automatic void model();
      bit stream[$];
      stream.delete();
      for (int w = 0; w < NS; w++)
         for (int b = 31; b >= 0; b--) stream.push_back(win[w][b]);
      exp_ones  = 0;
      exp_trans = 0;
      foreach (stream[k]) begin
         if (stream[k]) exp_ones++;
         if (k > 0 && stream[k] != stream[k-1]) exp_trans++;
      end
      exp_pm = (exp_ones >= CENTRE - TOL) && (exp_ones <= CENTRE + TOL);
      exp_pr = (exp_trans >= CENTRE - TOL) && (exp_trans <= CENTRE + TOL);
   endfunction

   function automatic void fill(input logic [31:0] v);
      for (int i = 0; i < NS; i++) win[i] = v;
   endfunction

   // Drives one window from a negedge; records done latency and pulse count.
   task automatic run_window(input int max_gap, input bit mid_start, input bit start_at_done);
      int gap;
      busy_bad = 0;
      done_bad = 0;
      busy_after_done = 1'b0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < NS; i++) begin
         gap = $urandom_range(0, max_gap);
         for (int g = 0; g < gap; g++) begin
            bus.in_valid = 1'b0;
            bus.in_data  = $urandom;
            @(negedge clk);
            if (bus.busy !== 1'b1) busy_bad++;
            if (bus.done !== 1'b0) done_bad++;
         end
         bus.in_valid = 1'b1;
         bus.in_data  = win[i];
         bus.start    = mid_start && (i == 2);
         @(negedge clk);
         bus.start = 1'b0;
         if (bus.busy !== 1'b1) busy_bad++;
         if (bus.done !== 1'b0) done_bad++;
      end
      bus.in_valid = 1'b0;
      bus.in_data  = $urandom;
      lat = 0;
      pulses = 0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         bus.start = 1'b0;
         if (bus.done === 1'b1) begin
            pulses++;
            if (lat == 0) lat = c;
            if (start_at_done) bus.start = 1'b1;
         end
         if (c == lat + 1 && lat != 0) busy_after_done = bus.busy;
      end
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.start = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.pass_mono, bus.pass_runs} !== 4'b0) begin
         errors++; $display("FAIL reset_flags got %b want 0000", {bus.busy, bus.done, bus.pass_mono, bus.pass_runs});
      end
      checks++;
      if (bus.ones_count !== '0 || bus.trans_count !== '0) begin
         errors++; $display("FAIL reset_counts got %0d/%0d want 0/0", bus.ones_count, bus.trans_count);
      end
      checks++;
      if (dbg_state !== 2'd0) begin
         errors++; $display("FAIL reset_state got %0d want 0", dbg_state);
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic check_results(input string name);
      model();
      checks++;
      if (bus.ones_count !== exp_ones[LOG2_N+5:0]) begin
         errors++; $display("FAIL %s ones got %0d want %0d", name, bus.ones_count, exp_ones);
      end
      checks++;
      if (bus.trans_count !== exp_trans[LOG2_N+5:0]) begin
         errors++; $display("FAIL %s trans got %0d want %0d", name, bus.trans_count, exp_trans);
      end
      checks++;
      if (bus.pass_mono !== exp_pm || bus.pass_runs !== exp_pr) begin
         errors++; $display("FAIL %s pass got %b%b want %b%b", name, bus.pass_mono, bus.pass_runs, exp_pm, exp_pr);
      end
   endtask

   task automatic test_zeros();
      fill(32'h0000_0000);
      run_window(0, 1'b0, 1'b0);
      checks++;
      if (lat != 2) begin errors++; $display("FAIL zeros_latency got %0d want 2", lat); end
      check_results("zeros");
      checks++;
      if (bus.ones_count !== 0 || bus.pass_mono !== 1'b0) begin
         errors++; $display("FAIL zeros_const got %0d/%b want 0/0", bus.ones_count, bus.pass_mono);
      end
   endtask

   task automatic test_alternating();
      fill(32'hAAAA_AAAA);
      run_window(0, 1'b0, 1'b0);
      check_results("alt");
      checks++;
      if (bus.trans_count !== 127 || bus.pass_runs !== 1'b0) begin
         errors++; $display("FAIL alt_const got %0d/%b want 127/0", bus.trans_count, bus.pass_runs);
      end
   endtask

   task automatic test_gaps();
      fill(32'hCCCC_CCCC);
      run_window(3, 1'b0, 1'b0);
      check_results("gaps");
      checks++;
      if (busy_bad != 0 || done_bad != 0) begin
         errors++; $display("FAIL gaps_busy got busy_bad=%0d done_bad=%0d want 0/0", busy_bad, done_bad);
      end
      checks++;
      if (pulses != 1 || lat != 2) begin
         errors++; $display("FAIL gaps_done got pulses=%0d lat=%0d want 1/2", pulses, lat);
      end
      checks++;
      if (bus.trans_count !== 63 || bus.pass_runs !== 1'b1) begin
         errors++; $display("FAIL gaps_const got %0d/%b want 63/1", bus.trans_count, bus.pass_runs);
      end
   endtask

   task automatic test_mid_start();
      fill(32'hFFFF_0000);
      run_window(1, 1'b0, 1'b0);
      check_results("halves");
      fill(32'h1234_5678);
      run_window(1, 1'b1, 1'b0);
      checks++;
      if (lat != 2 || pulses != 1) begin
         errors++; $display("FAIL mid_start_count got lat=%0d pulses=%0d want 2/1", lat, pulses);
      end
      check_results("mid_start");
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_start_idle got busy=%b want 0", bus.busy); end
   endtask

   task automatic test_start_at_done();
      fill(32'h0F0F_0F0F);
      run_window(0, 1'b0, 1'b1);
      checks++;
      if (busy_after_done !== 1'b0) begin
         errors++; $display("FAIL start_at_done got busy=%b want 0", busy_after_done);
      end
      check_results("start_at_done");
   endtask

   task automatic test_mid_reset();
      int dseen;
      fill(32'hAAAA_AAAA);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = win[i];
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      rst = 1'b0;
      #1;
      checks++;
      if ({bus.busy, bus.done, bus.pass_mono, bus.pass_runs} !== 4'b0 || bus.ones_count !== '0 ||
          bus.trans_count !== '0 || dbg_state !== 2'd0) begin
         errors++; $display("FAIL mid_reset got busy=%b ones=%0d trans=%0d state=%0d want 0", bus.busy,
                            bus.ones_count, bus.trans_count, dbg_state);
      end
      @(negedge clk);
      rst = 1'b1;
      dseen = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus.done === 1'b1 || bus.busy === 1'b1) dseen++;
      end
      checks++;
      if (dseen != 0) begin errors++; $display("FAIL mid_reset_quiet got %0d active cycles want 0", dseen); end
      fill(32'hCCCC_CCCC);
      run_window(2, 1'b0, 1'b0);
      check_results("after_reset");
   endtask

   task automatic test_random();
      for (int t = 0; t < 12; t++) begin
         for (int i = 0; i < NS; i++) begin
            case ($urandom_range(0, 3))
               0: win[i] = $urandom;
               1: win[i] = 32'hAAAA_AAAA ^ (32'h1 << $urandom_range(0, 31));
               2: win[i] = {$urandom_range(0, 1) ? 16'hFFFF : 16'h0, 16'(($urandom))};
               default: win[i] = $urandom & $urandom;
            endcase
         end
         run_window(2, 1'b0, 1'b0);
         checks++;
         if (lat != 2 || pulses != 1) begin
            errors++; $display("FAIL rand%0d_done got lat=%0d pulses=%0d want 2/1", t, lat, pulses);
         end
         check_results($sformatf("rand%0d", t));
      end
   endtask

   task automatic test_back_to_back();
      fill(32'hFFFF_FFFF);
      run_window(0, 1'b0, 1'b0);
      check_results("ones_all");
      fill(32'h5555_5555);
      run_window(0, 1'b0, 1'b0);
      check_results("b2b_55");
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_zeros();
      test_alternating();
      test_gaps();
      test_mid_start();
      test_start_at_done();
      test_mid_reset();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running want finished");
      $fatal(1);
   end
endmodule
